// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: shared state encoding and counter sizing for the reset sequencer
package reset_seq_pkg;
  typedef enum logic [1:0] {ASSERT, WAIT_RDY, GAP, DONE} state_t;
  function automatic int cnt_w(input int a, input int b, input int c);
    int m;
    m = a > b ? a : b;
    m = m > c ? m : c;
    return $clog2(m + 1);
  endfunction
endpackage

// File: rtl/reset_bridge.sv
// reset_bridge: async-assert, sync-release bridge for the active-low reset
module reset_bridge (
  input  logic clk,
  input  logic async_rst_n,
  output logic rst_sync_n
);
  logic meta;
  always_ff @(posedge clk or negedge async_rst_n)
    if (!async_rst_n) {rst_sync_n, meta} <= 2'b00;
    else {rst_sync_n, meta} <= {meta, 1'b1};
endmodule

// File: rtl/reset_seq.sv
// reset_seq: stretches, then releases per-channel resets in order gated by ch_ready
module reset_seq
  import reset_seq_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int STRETCH_LEN = 16,
  parameter int STAGE_GAP   = 4,
  parameter int FILT_LEN    = 3,
  parameter int TIMEOUT     = 1000
) (
  input  logic              clk,
  input  logic              async_rst_n,
  input  logic              ext_rst_req,
  input  logic              sw_rst_req,
  input  logic [NUM_CH-1:0] ch_ready,
  output logic [NUM_CH-1:0] rst_out,
  output logic              seq_busy,
  output logic              seq_done,
  output logic [NUM_CH-1:0] timeout_err,
  output logic [7:0]        rst_count
);
  localparam int CW = cnt_w(STRETCH_LEN, STAGE_GAP, TIMEOUT);
  localparam int KW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int FW = $clog2(FILT_LEN + 1);
  if (NUM_CH < 1 || NUM_CH > 16 || STRETCH_LEN < 1 || STAGE_GAP < 0 || FILT_LEN < 1 || TIMEOUT < 1)
    $error("reset_seq: illegal parameter value");
  logic rst_sync_n;
  reset_bridge u_bridge (.clk(clk), .async_rst_n(async_rst_n), .rst_sync_n(rst_sync_n));
  logic [1:0] ext_sync;
  logic [FW-1:0] filt_cnt;
  logic ext_acc, req, rdy, tmo, last;
  state_t state;
  logic [CW-1:0] cnt;
  logic [KW-1:0] k;
  always_ff @(posedge clk or negedge async_rst_n)
    if (!async_rst_n) begin
      ext_sync <= '0;
      filt_cnt <= '0;
    end else begin
      ext_sync <= {ext_sync[0], ext_rst_req};
      filt_cnt <= !ext_sync[1] ? '0 : ext_acc ? filt_cnt : filt_cnt + 1'b1;
    end
  assign ext_acc  = filt_cnt == FW'(FILT_LEN);
  assign req      = ext_acc | sw_rst_req;
  assign rdy      = ch_ready[k];
  assign tmo      = cnt == CW'(TIMEOUT - 1);
  assign last     = k == KW'(NUM_CH - 1);
  assign seq_busy = |rst_out;
  assign seq_done = state == DONE;
  // Power-on hold and later requests both land in ASSERT; only requests leaving a non-ASSERT state are counted
  always_ff @(posedge clk or negedge async_rst_n)
    if (!async_rst_n) begin
      state       <= ASSERT;
      cnt         <= '0;
      k           <= '0;
      rst_out     <= '1;
      timeout_err <= '0;
      rst_count   <= '0;
    end else if (!rst_sync_n) begin
      state       <= ASSERT;
      cnt         <= '0;
      k           <= '0;
      rst_out     <= '1;
      timeout_err <= '0;
      rst_count   <= '0;
    end else if (req) begin
      state       <= ASSERT;
      cnt         <= '0;
      k           <= '0;
      rst_out     <= '1;
      timeout_err <= '0;
      if (state != ASSERT && rst_count != 8'hff) rst_count <= rst_count + 1'b1;
    end else
      case (state)
        ASSERT:
          if (cnt == CW'(STRETCH_LEN - 1)) begin
            state <= WAIT_RDY;
            cnt   <= '0;
          end else cnt <= cnt + 1'b1;
        WAIT_RDY:
          if (rdy || tmo) begin
            rst_out[k] <= 1'b0;
            cnt        <= '0;
            if (!rdy) timeout_err[k] <= 1'b1;
            state <= last ? DONE : (STAGE_GAP == 0 ? WAIT_RDY : GAP);
            if (!last && STAGE_GAP == 0) k <= k + 1'b1;
          end else cnt <= cnt + 1'b1;
        GAP:
          if (cnt == CW'(STAGE_GAP - 1)) begin
            state <= WAIT_RDY;
            cnt   <= '0;
            k     <= k + 1'b1;
          end else cnt <= cnt + 1'b1;
        default: ;
      endcase
endmodule

// File: doc/reset_seq.md
RESET_SEQ -- requirements
Module: reset_seq

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of sequenced reset outputs, legal 1..16.
REQ-002 SHALL have parameter STRETCH_LEN, default 16: minimum cycles all outputs are held asserted, legal >=1.
REQ-003 SHALL have parameter STAGE_GAP, default 4: idle cycles between successive channel releases, legal >=0.
REQ-004 SHALL have parameter FILT_LEN, default 3: consecutive synchronised-high cycles needed to accept ext_rst_req, legal >=1.
REQ-005 SHALL have parameter TIMEOUT, default 1000: maximum wait cycles for ch_ready per channel, legal >=1.
REQ-006 SHALL reject illegal parameter values at elaboration.
REQ-007 clk  input  1  sole clock.
REQ-008 async_rst_n  input  1  asynchronous, active-low reset.
REQ-009 ext_rst_req  input  1  asynchronous active-high reset request.
REQ-010 sw_rst_req  input  1  clk-synchronous single-cycle reset request pulse.
REQ-011 ch_ready  input  NUM_CH  per-channel release prerequisite (e.g. PLL lock), clk-synchronous.
REQ-012 rst_out  output  NUM_CH  active-high channel resets; bit 0 released first.
REQ-013 seq_busy  output  1  high whenever any rst_out bit is high.
REQ-014 seq_done  output  1  high only in state DONE.
REQ-015 timeout_err  output  NUM_CH  sticky per-channel timeout flags.
REQ-016 rst_count  output  8  saturating count of request-triggered sequences.

Function
REQ-017 States SHALL be ASSERT, WAIT_RDY, GAP, DONE, with channel index k and a single down/up counter sized $clog2(max(STRETCH_LEN,STAGE_GAP,TIMEOUT)+1).
REQ-018 ASSERT: all rst_out high; after STRETCH_LEN cycles in ASSERT, go to WAIT_RDY with k=0.
REQ-019 WAIT_RDY: when ch_ready[k] is sampled high, rst_out[k] SHALL deassert on the next edge; go to GAP if k<NUM_CH-1, else DONE.
REQ-020 WAIT_RDY: if ch_ready[k] is still low after TIMEOUT cycles, set timeout_err[k] and release rst_out[k] as in REQ-019.
REQ-021 GAP: hold for STAGE_GAP cycles, then WAIT_RDY with k+1; STAGE_GAP=0 SHALL skip GAP.
REQ-022 Released channels SHALL stay released until the next ASSERT entry; release order SHALL be strictly 0..NUM_CH-1.
REQ-023 ext_rst_req SHALL pass a 2-flop synchroniser and then a FILT_LEN consecutive-high filter; shorter pulses are ignored.
REQ-024 An accepted request (filtered ext or sw_rst_req) in any state SHALL reassert all rst_out on the next edge and enter ASSERT with the counter cleared.
REQ-025 While filtered ext request stays high, ASSERT SHALL hold with the counter cleared; stretch counts from request drop.
REQ-026 Simultaneous ext and sw requests SHALL count as one event.
REQ-027 rst_count SHALL increment on each ASSERT entry from a non-ASSERT state by request, saturating at 255; power-on entry does not count.
REQ-028 timeout_err SHALL clear on every ASSERT entry.

Reset
REQ-029 async_rst_n low SHALL immediately (combinationally via async preset) drive rst_out all-ones, seq_busy=1, seq_done=0, timeout_err=0, rst_count=0, state ASSERT.
REQ-030 async_rst_n deassertion SHALL be synchronised with 2 flops; first ASSERT counting cycle is the 2nd rising edge after release.
REQ-031 async_rst_n assertion mid-sequence SHALL abort the sequence and restart from REQ-029.

Structure
REQ-032 State encoding and the counter-width function SHALL live in the shared package reset_seq_pkg.
REQ-033 The async_rst_n synchroniser SHALL be the sub-module reset_bridge; all other logic stays in reset_seq.

Verification (NUM_CH=3, STRETCH_LEN=16, STAGE_GAP=4, FILT_LEN=3, TIMEOUT=100; T = first ASSERT cycle)
REQ-034 Power-up, ch_ready=3'b111 -> rst_out[0] low at T+17, rst_out[1] at T+22, rst_out[2] and seq_done at T+27, rst_count=0.
REQ-035 ch_ready[1] tied low -> timeout_err=3'b010 after 100 wait cycles, rst_out[1] released anyway, seq_done follows.
REQ-036 ext_rst_req pulses of 2 cycles -> no effect; pulse of 5 cycles in DONE -> all rst_out high, rst_count=1, full re-sequence after request drops.
REQ-037 sw_rst_req during GAP of channel 1 -> rst_out=3'b111 next edge, timeout_err cleared, restart at T'+17.
REQ-038 async_rst_n low mid-WAIT_RDY -> rst_out=3'b111 without clock edge; 300 requests -> rst_count saturates at 255.
